codec_channel_scheduler: RTL

- Sequences one audio frame per codec sample period through a single shared channel-processing pipeline (encoder / noisy channel / decoder).
- Replaces the two per-channel pipeline copies with one pipeline that is time-multiplexed between the left and right channels.
- Sits between audio_codec (read/write handshake) and the processing pipeline (valid/ready/done handshake).
- Also keeps per-channel decoder error statistics and guards against a stalled pipeline with a timeout bypass.

---
 rtl/audio_sched_pkg.sv | 16 +
 rtl/codec_channel_scheduler_sat_counter.sv | 23 ++
 rtl/codec_channel_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/audio_sched_pkg.sv
// Shared types for the codec channel scheduler: FSM state encoding and channel ids.
package audio_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_L,
        WAIT_L,
        ISSUE_R,
        WAIT_R,
        WRITE
    } sched_state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/codec_channel_scheduler_sat_counter.sv
// Saturating up-counter with synchronous active-low clear, used for decoder error statistics.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/codec_channel_scheduler.sv
// Time-multiplexes one encoder/channel/decoder pipeline between the left and right codec
// samples of each frame, with per-channel error statistics and a stalled-pipeline bypass.
module codec_channel_scheduler
    import audio_sched_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int TIMEOUT = 255,
    parameter int ERR_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              read_ready,
    output logic              read,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    input  logic              write_ready,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              proc_valid,
    input  logic              proc_ready,
    output logic              proc_channel,
    output logic [DATA_W-1:0] proc_data,
    input  logic              proc_done,
    input  logic [DATA_W-1:0] proc_result,
    input  logic              proc_error,
    output logic [ERR_W-1:0]  err_count_left,
    output logic [ERR_W-1:0]  err_count_right,
    output logic              timeout_flag,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    sched_state_t      r_state;
    sched_state_t      w_next;
    logic [DATA_W-1:0] r_samp_l;
    logic [DATA_W-1:0] r_samp_r;
    logic [DATA_W-1:0] r_res_l;
    logic [DATA_W-1:0] r_wd_l;
    logic [DATA_W-1:0] r_wd_r;
    logic [CNT_W-1:0]  r_tcnt;
    logic              r_tflag;
    logic              w_read;
    logic              w_write;
    logic              w_in_wait;
    logic              w_at_last;
    logic              w_wait_done;
    logic              w_expire;
    logic              w_accept;
    logic              w_err_inc_l;
    logic              w_err_inc_r;

    assign w_in_wait   = (r_state == WAIT_L) || (r_state == WAIT_R);
    assign w_at_last   = (r_tcnt == LAST_CNT);
    assign w_wait_done = w_in_wait && (proc_done || w_at_last);
    // A result arriving on the expiry cycle takes priority over the bypass.
    assign w_expire    = w_in_wait && !proc_done && w_at_last;
    assign w_accept    = proc_valid && proc_ready;

    always_comb begin
        w_next       = r_state;
        w_read       = 1'b0;
        w_write      = 1'b0;
        proc_valid   = 1'b0;
        proc_channel = CH_LEFT;
        proc_data    = '0;
        case (r_state)
            IDLE: begin
                if (read_ready) begin
                    w_read = 1'b1;
                    w_next = ISSUE_L;
                end
            end
            ISSUE_L: begin
                proc_valid = 1'b1;
                proc_data  = r_samp_l;
                if (proc_ready) w_next = WAIT_L;
            end
            WAIT_L: begin
                if (w_wait_done) w_next = ISSUE_R;
            end
            ISSUE_R: begin
                proc_valid   = 1'b1;
                proc_channel = CH_RIGHT;
                proc_data    = r_samp_r;
                if (proc_ready) w_next = WAIT_R;
            end
            WAIT_R: begin
                if (w_wait_done) w_next = WRITE;
            end
            WRITE: begin
                if (write_ready) begin
                    w_write = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Codec handshakes must not fire while reset is held, even though the state is IDLE.
    assign read  = w_read && reset_n;
    assign write = w_write && reset_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_samp_l <= '0;
            r_samp_r <= '0;
            r_res_l  <= '0;
            r_wd_l   <= '0;
            r_wd_r   <= '0;
            r_tcnt   <= '0;
            r_tflag  <= 1'b0;
        end else begin
            if (read) begin
                r_samp_l <= readdata_left;
                r_samp_r <= readdata_right;
            end
            if (w_accept) begin
                r_tcnt <= '0;
            end else if (w_in_wait && !proc_done && !w_at_last) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if (w_expire) begin
                r_tflag <= 1'b1;
            end
            if ((r_state == WAIT_L) && w_wait_done) begin
                r_res_l <= proc_done ? proc_result : r_samp_l;
            end
            // Codec-facing registers change only when a complete frame is ready to write.
            if ((r_state == WAIT_R) && w_wait_done) begin
                r_wd_l <= r_res_l;
                r_wd_r <= proc_done ? proc_result : r_samp_r;
            end
        end
    end

    assign w_err_inc_l = (r_state == WAIT_L) && proc_done && proc_error;
    assign w_err_inc_r = (r_state == WAIT_R) && proc_done && proc_error;

    sat_counter #(.WIDTH(ERR_W)) u_err_left (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_inc   (w_err_inc_l),
        .o_count (err_count_left)
    );

    sat_counter #(.WIDTH(ERR_W)) u_err_right (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_inc   (w_err_inc_r),
        .o_count (err_count_right)
    );

    assign writedata_left  = r_wd_l;
    assign writedata_right = r_wd_r;
    assign timeout_flag    = r_tflag;
    assign busy            = (r_state != IDLE);

endmodule
